// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-length LED blinks separated by a dark gap.
// Events arriving mid-blink are queued in a saturating counter; dropped events raise a sticky flag.
module pulse_stretcher #(
    parameter int ON_CYCLES  = 10_000_000,
    parameter int GAP_CYCLES = 5_000_000,
    parameter int PEND_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_p,
    input  logic              clr_ovf,
    output logic              out_led,
    output logic              busy,
    output logic              done_p,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [PEND_W-1:0] pend_nxt;
    logic              phase_end;
    logic              enq;
    logic              drop;
    logic              ovf_nxt;
    logic              led_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    // State register; every output is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            out_led  <= 1'b0;
            busy     <= 1'b0;
            done_p   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pending  <= pend_nxt;
            overflow <= ovf_nxt;
            out_led  <= led_nxt;
            busy     <= busy_nxt;
            done_p   <= done_nxt;
        end
    end

    // Next-state, counter and queue logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pending;
        drop      = 1'b0;
        phase_end = (cnt == '0);
        // On the final GAP cycle an incoming event is consumed by the restart, never queued.
        enq = in_p && ((state == ON) || ((state == GAP) && !phase_end));

        if (enq) begin
            if (pending == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pend_nxt = pending + 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (in_p) begin
                    state_nxt = ON;
                    cnt_nxt   = ON_LOAD;
                end
            end
            ON: begin
                if (phase_end) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                if (phase_end) begin
                    if (in_p || (pending != '0)) begin
                        state_nxt = ON;
                        cnt_nxt   = ON_LOAD;
                        // A simultaneous event replaces the dequeued one, leaving pending as is.
                        if (!in_p) begin
                            pend_nxt = pending - 1'b1;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        ovf_nxt = drop | (overflow & ~clr_ovf);
    end

    // Output decode from the upcoming state.
    always_comb begin
        led_nxt  = (state_nxt == ON);
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == ON) && (state_nxt == GAP);
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed vector table, async-reset sequence,
// and random pulses checked against an absolute-time blink model.
module tb_pulse_stretcher;

    localparam int ON   = 4;
    localparam int GAP  = 2;
    localparam int PW   = 2;
    localparam int PMAX = 3;
    localparam int OW   = 4 + PW;

    typedef struct {
        bit            rst_before;
        bit            in_p;
        bit            clr;
        logic [OW-1:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_p;
    logic          clr_ovf;
    logic          out_led;
    logic          busy;
    logic          done_p;
    logic [PW-1:0] pending;
    logic          overflow;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];
    logic [OW-1:0] exp_q[$];

    int m_n;
    bit m_active;
    int m_start;
    int m_pend;
    bit m_ovf;

    pulse_stretcher #(
        .ON_CYCLES (ON),
        .GAP_CYCLES(GAP),
        .PEND_W    (PW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_p    (in_p),
        .clr_ovf (clr_ovf),
        .out_led (out_led),
        .busy    (busy),
        .done_p  (done_p),
        .pending (pending),
        .overflow(overflow)
    );

    // Clock and reset
    always #5 clk = ~clk;

    function automatic logic [OW-1:0] pack(bit led, bit bsy, bit dn, int pend, bit ovf);
        return {led, bsy, dn, PW'(pend), ovf};
    endfunction

    function automatic void add(bit r, bit i, bit c, bit led, bit bsy, bit dn, int pend, bit ovf);
        vec_t v;
        v.rst_before = r;
        v.in_p       = i;
        v.clr        = c;
        v.exp        = pack(led, bsy, dn, pend, ovf);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [OW-1:0] exp);
        logic [OW-1:0] act;
        act = {out_led, busy, done_p, pending, overflow};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got led=%b busy=%b done=%b pend=%0d ovf=%b, want led=%b busy=%b done=%b pend=%0d ovf=%b",
                     name, act[OW-1], act[OW-2], act[OW-3], act[PW:1], act[0],
                     exp[OW-1], exp[OW-2], exp[OW-3], exp[PW:1], exp[0]);
        end
    endtask

    // Driver tasks
    task automatic do_reset();
        rst     = 1'b1;
        in_p    = 1'b0;
        clr_ovf = 1'b0;
        @(posedge clk);
        #1;
        check("reset", pack(0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic apply(input bit i, input bit c);
        in_p    = i;
        clr_ovf = c;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a blink is described by its start cycle; phase follows from elapsed time.
    function automatic void model_reset();
        m_n      = 0;
        m_active = 0;
        m_start  = 0;
        m_pend   = 0;
        m_ovf    = 0;
    endfunction

    function automatic logic [OW-1:0] model_step(bit i, bit c);
        bit drop;
        int e;
        drop = 0;
        e    = m_n - m_start;
        if (!m_active) begin
            if (i) begin
                m_active = 1;
                m_start  = m_n + 1;
            end
        end else if (e == ON + GAP - 1) begin
            if (i || m_pend > 0) begin
                m_pend  = m_pend + int'(i) - 1;
                m_start = m_n + 1;
            end else begin
                m_active = 0;
            end
        end else if (i) begin
            if (m_pend == PMAX) drop = 1;
            else m_pend++;
        end
        if (drop) m_ovf = 1;
        else if (c) m_ovf = 0;
        m_n++;
        e = m_n - m_start;
        if (m_active) return pack(e < ON, 1, e == ON, m_pend, m_ovf);
        return pack(0, 0, 0, m_pend, m_ovf);
    endfunction

    initial begin
        int burst;
        logic [OW-1:0] e;
        bit ri;
        bit rc;

        // Each entry: inputs during cycle k, expected outputs during cycle k+1.
        // Single pulse
        add(1, 1, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // Pulses at 0 and 2
        add(1, 1, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 1, 1, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // Held input: saturation, overflow, dequeue, clear
        add(1, 1, 0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 1, 1, 0, 1, 0);
        add(0, 1, 0, 1, 1, 0, 2, 0);
        add(0, 1, 0, 1, 1, 0, 3, 0);
        add(0, 1, 0, 0, 1, 1, 3, 1);
        add(0, 1, 0, 0, 1, 0, 3, 1);
        add(0, 0, 0, 1, 1, 0, 2, 1);
        add(0, 0, 0, 1, 1, 0, 2, 1);
        add(0, 0, 1, 1, 1, 0, 2, 0);
        add(0, 0, 0, 1, 1, 0, 2, 0);
        add(0, 0, 0, 0, 1, 1, 2, 0);
        add(0, 0, 0, 0, 1, 0, 2, 0);
        add(0, 0, 0, 1, 1, 0, 1, 0);
        // Final-GAP event with nothing queued
        add(1, 1, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 1, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // Final-GAP event with one queued
        add(1, 1, 0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 1, 1, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 1, 0);
        add(0, 1, 0, 1, 1, 0, 1, 0);
        // Drop with clear in the same cycle, then saturated final-GAP event
        add(1, 1, 0, 1, 1, 0, 0, 0);
        add(0, 1, 0, 1, 1, 0, 1, 0);
        add(0, 1, 0, 1, 1, 0, 2, 0);
        add(0, 1, 0, 1, 1, 0, 3, 0);
        add(0, 1, 1, 0, 1, 1, 3, 1);
        add(0, 0, 1, 0, 1, 0, 3, 0);
        add(0, 1, 0, 1, 1, 0, 3, 0);

        rst     = 1'b1;
        in_p    = 1'b0;
        clr_ovf = 1'b0;
        do_reset();

        foreach (vecs[k]) begin
            if (vecs[k].rst_before) do_reset();
            apply(vecs[k].in_p, vecs[k].clr);
            check($sformatf("vec%0d", k), vecs[k].exp);
        end

        // Asynchronous reset mid-blink with one event queued
        do_reset();
        apply(1, 0);
        check("ar_c1", pack(1, 1, 0, 0, 0));
        apply(1, 0);
        check("ar_c2", pack(1, 1, 0, 1, 0));
        in_p = 1'b0;
        #4;
        rst = 1'b1;
        #1;
        check("ar_async", pack(0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            apply(0, 0);
            check("ar_quiet", pack(0, 0, 0, 0, 0));
        end
        apply(1, 0);
        check("ar_new", pack(1, 1, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            apply(0, 0);
            check("ar_new_on", pack(1, 1, 0, 0, 0));
        end
        apply(0, 0);
        check("ar_new_done", pack(0, 1, 1, 0, 0));

        // Random stimulus against the model
        do_reset();
        model_reset();
        burst = 0;
        for (int k = 0; k < 800; k++) begin
            if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(2, 8);
            if (burst > 0) begin
                ri = 1'b1;
                burst--;
            end else begin
                ri = ($urandom_range(0, 9) < 2);
            end
            rc = ($urandom_range(0, 19) == 0);
            exp_q.push_back(model_step(ri, rc));
            apply(ri, rc);
            e = exp_q.pop_front();
            check($sformatf("rand%0d", k), e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
